// File: rtl/i2c_eeprom_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_if
// Bundles the I2C bus lines, the write-protect input, the status output and
// the external synchronous RAM port of the I2C EEPROM slave.
//   scl, sda_in   : bus lines as seen on the wire (asynchronous to clk)
//   sda_out       : open-drain drive, 0 = pull low, 1 = release
//   wp            : write protect, 1 = data bytes NACKed and not written
//   busy          : 1 while a transfer addressed to this device is active
//   mem_*         : RAM port; mem_rdata valid one clk after mem_addr
// Modports: slave (the EEPROM) and master (bus master + RAM side).
// ---------------------------------------------------------------------------
interface i2c_eeprom_slave_if #(
    parameter int ADDR_W = 13
);
    logic              scl;
    logic              sda_in;
    logic              sda_out;
    logic              wp;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport slave (
        input  scl, sda_in, wp, mem_rdata,
        output sda_out, busy, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output scl, sda_in, wp, mem_rdata,
        input  sda_out, busy, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
// 24Cxx-style I2C EEPROM slave working from oversampled SCL/SDA. Handles
// device-address matching, two address bytes, page-wrapped writes,
// sequential reads with whole-array wrap, repeated START, write protect and
// master ACK/NACK. Storage lives in an external synchronous RAM.
// Ports:
//   clk    : system clock, at least 8x the SCL frequency
//   reset  : asynchronous, active-high
//   bus    : i2c_eeprom_slave_if.slave (SCL/SDA, wp, busy, RAM port)
// Parameters:
//   ADDR_W   : memory address width (9..16)
//   DEV_ADDR : 7-bit device address
//   PAGE_W   : write page is 2**PAGE_W bytes
// ---------------------------------------------------------------------------
module i2c_eeprom_slave #(
    parameter int         ADDR_W   = 13,
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         PAGE_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    i2c_eeprom_slave_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEV,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WRITE,
        S_READ,
        S_WAIT_STOP
    } state_e;

    state_e            state_q, state_d;

    logic              scl_meta_q, scl_sync_q, scl_prev_q;
    logic              sda_meta_q, sda_sync_q, sda_prev_q;

    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              ack_q, ack_d;      // inside the 9th (acknowledge) clock
    logic              mack_q, mack_d;    // that 9th clock carries the master's ACK
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              sda_out_q, sda_out_d;
    logic              fetch_q, fetch_d;  // RAM address issued this clk
    logic              load_q;            // RAM data arrives this clk

    logic              scl_rise, scl_fall, start_det, stop_det;
    logic              busy;

    // Two-flop synchronisers plus one history flop for edge detection.
    // They reset to the idle-high bus level so reset release is not seen as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= bus.sda_in;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    assign start_det =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_det  =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;

    // State register (with the datapath registers it steers).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            ack_q       <= 1'b0;
            mack_q      <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            sda_out_q   <= 1'b1;
            fetch_q     <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ack_q       <= ack_d;
            mack_q      <= mack_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            sda_out_q   <= sda_out_d;
            fetch_q     <= fetch_d;
            load_q      <= fetch_q;
        end
    end

    // Next-state logic. START/STOP are checked first so they win over any
    // bit or acknowledge activity detected in the same clock.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ack_d       = ack_q;
        mack_d      = mack_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        sda_out_d   = sda_out_q;
        fetch_d     = 1'b0;

        // RAM read data is registered one clk after the address was issued.
        if (load_q) begin
            tx_d = bus.mem_rdata;
        end

        if (start_det) begin
            state_d   = S_DEV;
            bit_cnt_d = '0;
            ack_d     = 1'b0;
            mack_d    = 1'b0;
            shift_d   = '0;
            sda_out_d = 1'b1;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            ack_d     = 1'b0;
            mack_d    = 1'b0;
            sda_out_d = 1'b1;
        end else if (state_q == S_IDLE || state_q == S_WAIT_STOP) begin
            sda_out_d = 1'b1;
        end else if (scl_rise) begin
            if (ack_q) begin
                if (mack_q) begin
                    if (!sda_sync_q) begin
                        // Master wants more: prefetch now so the byte is
                        // ready before the next SCL fall.
                        mem_addr_d = ptr_q;
                        ptr_d      = ptr_q + 1'b1;
                        fetch_d    = 1'b1;
                    end else begin
                        state_d   = S_WAIT_STOP;
                        sda_out_d = 1'b1;
                        ack_d     = 1'b0;
                        mack_d    = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
            end else if (bit_cnt_q < 4'd8) begin
                shift_d   = {shift_q[6:0], sda_sync_q};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (scl_fall) begin
            if (ack_q) begin
                // End of the 9th clock: release, or start the next read byte.
                ack_d     = 1'b0;
                mack_d    = 1'b0;
                bit_cnt_d = '0;
                sda_out_d = (state_q == S_READ) ? tx_q[7] : 1'b1;
            end else if (bit_cnt_q == 4'd8) begin
                ack_d     = 1'b1;
                sda_out_d = 1'b0;
                case (state_q)
                    S_DEV: begin
                        if (shift_q[7:1] == DEV_ADDR) begin
                            if (shift_q[0]) begin
                                state_d    = S_READ;
                                mem_addr_d = ptr_q;
                                ptr_d      = ptr_q + 1'b1;
                                fetch_d    = 1'b1;
                            end else begin
                                state_d = S_ADDR_HI;
                            end
                        end else begin
                            state_d   = S_WAIT_STOP;
                            sda_out_d = 1'b1;
                            ack_d     = 1'b0;
                        end
                    end
                    S_ADDR_HI: begin
                        ptr_d[ADDR_W-1:8] = shift_q[ADDR_W-9:0];
                        state_d           = S_ADDR_LO;
                    end
                    S_ADDR_LO: begin
                        ptr_d[7:0] = shift_q;
                        state_d    = S_WRITE;
                    end
                    S_WRITE: begin
                        if (!bus.wp) begin
                            mem_addr_d          = ptr_q;
                            mem_wdata_d         = shift_q;
                            mem_we_d            = 1'b1;
                            // Only the in-page bits advance: writes wrap in the page.
                            ptr_d[PAGE_W-1:0]   = ptr_q[PAGE_W-1:0] + 1'b1;
                        end else begin
                            sda_out_d = 1'b1;
                        end
                    end
                    S_READ: begin
                        // Release for the master's ACK/NACK.
                        sda_out_d = 1'b1;
                        mack_d    = 1'b1;
                    end
                    default: begin
                        sda_out_d = 1'b1;
                    end
                endcase
            end else if (state_q == S_READ) begin
                sda_out_d = tx_q[3'd7 - bit_cnt_q[2:0]];
            end
        end
    end

    // Output logic.
    always_comb begin
        busy = 1'b0;
        case (state_q)
            S_IDLE, S_WAIT_STOP: busy = 1'b0;
            default:             busy = 1'b1;
        endcase
    end

    assign bus.busy      = busy;
    assign bus.sda_out   = sda_out_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_eeprom_slave
// Bit-banged I2C master plus a synchronous RAM model around i2c_eeprom_slave.
// Stimulus pushes expected events (ACK bits, RAM writes, read bytes, status
// snapshots) into a scoreboard queue; a monitor pops and compares them as the
// DUT produces the matching outputs.
// ---------------------------------------------------------------------------
module tb_i2c_eeprom_slave;

    localparam int ADDR_W = 13;
    localparam logic [2:0] K_ACK = 3'd0;
    localparam logic [2:0] K_WR  = 3'd1;
    localparam logic [2:0] K_RD  = 3'd2;
    localparam logic [2:0] K_ST  = 3'd3;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic m_sda;

    i2c_eeprom_slave_if #(.ADDR_W(ADDR_W)) bus ();

    i2c_eeprom_slave #(
        .ADDR_W  (ADDR_W),
        .DEV_ADDR(7'h50),
        .PAGE_W  (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of master and slave.
    assign bus.sda_in = m_sda & bus.sda_out;

    // Synchronous RAM, registered read.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Scoreboard.
    ev_t   exp_q[$];
    string exp_name_q[$];
    ev_t   obs_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic expect_ev(input logic [2:0] kind, input logic [31:0] val, input string name);
        exp_q.push_back('{kind: kind, val: val});
        exp_name_q.push_back(name);
    endtask

    task automatic observe(input logic [2:0] kind, input logic [31:0] val);
        obs_q.push_back('{kind: kind, val: val});
    endtask

    always @(negedge clk) begin
        ev_t   o;
        ev_t   e;
        string nm;
        if (bus.mem_we) obs_q.push_back('{kind: K_WR, val: {8'h00, 16'(bus.mem_addr), bus.mem_wdata}});
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected: got kind %0d val %h, required nothing", o.kind, o.val);
            end else begin
                e  = exp_q.pop_front();
                nm = exp_name_q.pop_front();
                if (e !== o) begin
                    n_bad++;
                    $display("FAIL %s: got kind %0d val %h, required kind %0d val %h",
                             nm, o.kind, o.val, e.kind, e.val);
                end else begin
                    $display("chk %s: kind %0d val %h ok", nm, o.kind, o.val);
                end
            end
        end
    end

    // Bus master primitives. Each leaves SCL low, 5 clks into the low phase.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;
        wait_clk(5);
        bus.scl = 1'b1;
        wait_clk(5);
        r = bus.sda_in;
        wait_clk(5);
        bus.scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic start_cond();
        m_sda = 1'b1;
        wait_clk(5);
        bus.scl = 1'b1;
        wait_clk(5);
        m_sda = 1'b0;
        wait_clk(5);
        bus.scl = 1'b0;
        wait_clk(5);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0;
        wait_clk(5);
        bus.scl = 1'b1;
        wait_clk(5);
        m_sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
        logic r;
        expect_ev(K_ACK, {31'd0, exp_ack}, name);
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        observe(K_ACK, {31'd0, r});
    endtask

    task automatic recv_byte(input string name, input logic m_ack, input logic [7:0] exp_b);
        logic       r;
        logic [7:0] d;
        expect_ev(K_RD, {24'd0, exp_b}, name);
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(m_ack, r);
        observe(K_RD, {24'd0, d});
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        expect_ev(K_WR, {8'h00, a, d}, "mem_write");
    endtask

    // Status word: {busy, sda_out, mem_we, 5'b0, mem_wdata, mem_addr(16)}
    task automatic stat(input string name, input logic [31:0] e);
        expect_ev(K_ST, e, name);
        observe(K_ST, {bus.busy, bus.sda_out, bus.mem_we, 5'b0, bus.mem_wdata, 16'(bus.mem_addr)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] <= 8'(i * 7 + 3);
        reset   = 1'b1;
        bus.scl = 1'b1;
        bus.wp  = 1'b0;
        m_sda   = 1'b1;
        wait_clk(4);
        stat("reset_state", 32'h4000_0000);
        reset = 1'b0;
        wait_clk(10);

        // Plain write of 0x5A at 0x0123.
        start_cond();
        stat("busy_after_start", 32'hC000_0000);
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h01, 1'b0);
        send_byte("addr_lo", 8'h23, 1'b0);
        expect_wr(16'h0123, 8'h5A);
        send_byte("data_5a", 8'h5A, 1'b0);
        stop_cond();
        stat("idle_after_stop", 32'h405A_0123);

        // Random read back of 0x0123 through a repeated START.
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h01, 1'b0);
        send_byte("addr_lo", 8'h23, 1'b0);
        start_cond();
        send_byte("dev_r", 8'hA1, 1'b0);
        recv_byte("rd_0123", 1'b1, 8'h5A);
        stat("wait_stop_after_nack", 32'h405A_0123);
        stop_cond();

        // Page wrap: three bytes starting at the last byte of a 64-byte page.
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h01, 1'b0);
        send_byte("addr_lo", 8'h3F, 1'b0);
        expect_wr(16'h013F, 8'h11);
        send_byte("pg_0", 8'h11, 1'b0);
        expect_wr(16'h0100, 8'h22);
        send_byte("pg_1", 8'h22, 1'b0);
        expect_wr(16'h0101, 8'h33);
        send_byte("pg_2", 8'h33, 1'b0);
        stop_cond();

        // Sequential read across the top of the array; high byte bits above ADDR_W ignored.
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi_ff", 8'hFF, 1'b0);
        send_byte("addr_lo", 8'hFF, 1'b0);
        start_cond();
        send_byte("dev_r", 8'hA1, 1'b0);
        recv_byte("rd_1fff", 1'b0, 8'hFC);
        recv_byte("rd_0000", 1'b1, 8'h03);
        stop_cond();

        // Foreign device address is ignored, next START addresses us again.
        start_cond();
        send_byte("dev_a4_nack", 8'hA4, 1'b1);
        stat("not_busy_foreign", 32'h4033_0000);
        start_cond();
        send_byte("dev_w_again", 8'hA0, 1'b0);
        stop_cond();

        // Write protect: NACK without write, pointer kept for the next byte.
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h00, 1'b0);
        send_byte("addr_lo", 8'h10, 1'b0);
        bus.wp = 1'b1;
        send_byte("wp_nack", 8'h77, 1'b1);
        bus.wp = 1'b0;
        expect_wr(16'h0010, 8'h88);
        send_byte("after_wp", 8'h88, 1'b0);
        stop_cond();

        // Reset while the slave is driving ACK low.
        start_cond();
        begin
            logic r;
            for (int i = 7; i >= 0; i--) bit_xfer(1'(8'hA0 >> i), r);
        end
        stat("acking_before_reset", 32'h8088_0010);
        reset = 1'b1;
        wait_clk(1);
        stat("reset_mid_transfer", 32'h4000_0000);
        reset = 1'b0;
        wait_clk(5);
        stop_cond();

        // Normal operation after reset: write then read back.
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h00, 1'b0);
        send_byte("addr_lo", 8'h05, 1'b0);
        expect_wr(16'h0005, 8'h99);
        send_byte("data_99", 8'h99, 1'b0);
        stop_cond();
        start_cond();
        send_byte("dev_w", 8'hA0, 1'b0);
        send_byte("addr_hi", 8'h00, 1'b0);
        send_byte("addr_lo", 8'h05, 1'b0);
        start_cond();
        send_byte("dev_r", 8'hA1, 1'b0);
        recv_byte("rd_0005", 1'b1, 8'h99);
        stop_cond();

        // Drain: anything still expected was never produced.
        for (int t = 0; t < 200 && (exp_q.size() > 0 || obs_q.size() > 0); t++) wait_clk(1);
        wait_clk(2);
        while (exp_q.size() > 0) begin
            ev_t   e;
            string nm;
            e  = exp_q.pop_front();
            nm = exp_name_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got nothing, required kind %0d val %h", nm, e.kind, e.val);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
